vmac_operand_fetch: RTL
=======================

Name: vmac_operand_fetch

Overview:
Upstream operand sequencer for the vector MAC datapath.
- Reads operand triples (A, B, C), each one VLEN-wide packed vector, from the shared synchronous-read operand memory.
- Presents each triple on a valid/ready interface to the MAC input registers.
- Replaces hand-driven operand injection with a programmable burst of num_vec triples starting at base_addr.

Parameters:
VLEN, 48, packed vector width in bits (VECTOR lanes x I_WIDTH)
I_WIDTH, 16, lane width; lane i = bits [I_WIDTH*i +: I_WIDTH], passed through unmodified
VECTOR, 3, lanes per vector (VLEN = VECTOR*I_WIDTH, checked at elaboration)
ADDR_W, 8, memory word address width

Ports:
clk  in  1  single clock, all state on rising edge
reset  in  1  asynchronous, active-low; asserted (0) clears all state immediately
start  in  1  begin a burst; sampled only in IDLE
base_addr  in  ADDR_W  word address of first A vector; latched on accepted start
num_vec  in  ADDR_W  number of triples to fetch; latched on accepted start
mem_en  out  1  memory read enable
mem_addr  out  ADDR_W  memory read address
mem_dout  in  VLEN  read data, valid one cycle after mem_en/mem_addr
a_out  out  VLEN  packed A operand
b_out  out  VLEN  packed B operand
c_out  out  VLEN  packed C operand
op_valid  out  1  a_out/b_out/c_out hold a complete triple
op_ready  in  1  MAC stage accepts triple when op_valid & op_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of burst

Behaviour:
- Memory layout: triple k at ptr = base_addr + 3k: A at ptr, B at ptr+1, C at ptr+2. All address arithmetic is modulo 2^ADDR_W, with silent wrap at the top of memory.
- Reset (reset=0): state=IDLE; mem_en=0, mem_addr=0, a_out/b_out/c_out=0, op_valid=0, busy=0, done=0; internal ptr and count cleared. Applies at any time, including mid-burst or during a stalled PRESENT. No partial triple survives.
- States: IDLE, REQ_A, REQ_B, REQ_C, WAIT_C, PRESENT, DONE.
- IDLE:
  - start=1 and num_vec!=0: latch ptr=base_addr and count=num_vec, go to REQ_A.
  - start=1 and num_vec==0: go to DONE (no memory access).
- REQ_A: mem_en=1, mem_addr=ptr -> REQ_B.
- REQ_B: mem_en=1, mem_addr=ptr+1; a_out<=mem_dout at edge -> REQ_C.
- REQ_C: mem_en=1, mem_addr=ptr+2; b_out<=mem_dout -> WAIT_C.
- WAIT_C: mem_en=0; c_out<=mem_dout -> PRESENT.
- PRESENT: op_valid=1; a_out/b_out/c_out held stable while op_ready=0 (unbounded stall allowed).
  - On handshake with count==1: go to DONE.
  - On handshake with count>1: count-1, ptr+3, go to REQ_A.
- DONE: done=1 for exactly one cycle -> IDLE.
- mem_en is 0 in IDLE, WAIT_C, PRESENT and DONE. mem_addr holds its last value when mem_en=0.
- op_valid is high only in PRESENT and drops the cycle after the handshake.
- Latency: start sampled at edge E0 -> op_valid high after edge E0+4. Per triple with op_ready tied high: 5 cycles.
- start while busy=1 is ignored; no queuing, and latched base_addr/num_vec are unaffected.
- op_ready while op_valid=0 is ignored.
- Operand registers keep their last values after the burst; op_valid=0 marks them stale.

Test Plan:
- Reset then idle: release reset, hold start=0 for 20 cycles -> all outputs 0, mem_en never asserted.
- Single triple: mem[0x10..0x12] = 0x000100020003 / 0x000400050006 / 0x000700080009; start, base=0x10, num=1, op_ready=1 -> mem_addr 0x10, 0x11, 0x12 on consecutive cycles; op_valid 4 cycles after start with a/b/c = those words; done pulses once, 1 cycle after handshake; busy back to 0.
- Backpressure: num=2, op_ready=0 for 10 cycles in first PRESENT -> outputs stable, no mem_en; after op_ready=1, second fetch starts at base+3, and done pulses only after the second handshake.
- Wrap: base=0xFE, num=1 -> addresses 0xFE, 0xFF, 0x00, data returned in correct A/B/C order.
- Zero/ignored start: num=0 -> done pulses 1 cycle later with no memory reads. start pulsed mid-burst -> ignored, triple count unchanged.
- Async reset mid-operation: assert reset during REQ_C and again during a stalled PRESENT -> outputs 0 immediately without a clock edge; a new start after release runs a clean burst from the new base.

Source files
------------

// File: rtl/vmac_operand_fetch.sv
// Operand sequencer for the vector MAC: fetches A/B/C vector triples from the
// synchronous-read operand memory and hands them to the MAC over valid/ready.
module vmac_operand_fetch #(
  parameter int VLEN    = 48,
  parameter int I_WIDTH = 16,
  parameter int VECTOR  = 3,
  parameter int ADDR_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_vec,
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [VLEN-1:0]   mem_dout,
  output logic [VLEN-1:0]   a_out,
  output logic [VLEN-1:0]   b_out,
  output logic [VLEN-1:0]   c_out,
  output logic              op_valid,
  input  logic              op_ready,
  output logic              busy,
  output logic              done
);

  // state   | meaning
  // IDLE    | waiting for start
  // REQ_A   | reading A at ptr
  // REQ_B   | reading B at ptr+1, capturing A
  // REQ_C   | reading C at ptr+2, capturing B
  // WAIT_C  | capturing C
  // PRESENT | triple valid, waiting for op_ready
  // DONE    | one-cycle end-of-burst pulse

  generate
    if (VLEN != VECTOR * I_WIDTH) begin : g_vlen_check
      $error("vmac_operand_fetch: VLEN must equal VECTOR*I_WIDTH");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_A   = 3'd1,
    REQ_B   = 3'd2,
    REQ_C   = 3'd3,
    WAIT_C  = 3'd4,
    PRESENT = 3'd5,
    DONE    = 3'd6
  } state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] ptr, ptr_nxt;
  logic [ADDR_W-1:0] count, count_nxt;
  logic [ADDR_W-1:0] addr_q, addr_nxt;
  logic [VLEN-1:0]   a_q, b_q, c_q;
  logic              cap_a, cap_b, cap_c;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ptr    <= '0;
      count  <= '0;
      addr_q <= '0;
    end else begin
      state  <= state_nxt;
      ptr    <= ptr_nxt;
      count  <= count_nxt;
      addr_q <= addr_nxt;
    end
  end

  // Address register is loaded on entry to each REQ state so it lines up with
  // the state, and simply holds its value while the memory is idle.
  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    count_nxt = count;
    addr_nxt  = addr_q;
    cap_a     = 1'b0;
    cap_b     = 1'b0;
    cap_c     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_vec != '0) begin
            ptr_nxt   = base_addr;
            count_nxt = num_vec;
            addr_nxt  = base_addr;
            state_nxt = REQ_A;
          end else begin
            state_nxt = DONE;
          end
        end
      end
      REQ_A: begin
        addr_nxt  = ptr + ADDR_W'(1);
        state_nxt = REQ_B;
      end
      REQ_B: begin
        cap_a     = 1'b1;
        addr_nxt  = ptr + ADDR_W'(2);
        state_nxt = REQ_C;
      end
      REQ_C: begin
        cap_b     = 1'b1;
        state_nxt = WAIT_C;
      end
      WAIT_C: begin
        cap_c     = 1'b1;
        state_nxt = PRESENT;
      end
      PRESENT: begin
        if (op_ready) begin
          if (count == ADDR_W'(1)) begin
            state_nxt = DONE;
          end else begin
            count_nxt = count - ADDR_W'(1);
            ptr_nxt   = ptr + ADDR_W'(3);
            addr_nxt  = ptr + ADDR_W'(3);
            state_nxt = REQ_A;
          end
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Lanes pass straight through; the whole packed word is captured at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q <= '0;
      b_q <= '0;
      c_q <= '0;
    end else begin
      if (cap_a) a_q <= mem_dout;
      if (cap_b) b_q <= mem_dout;
      if (cap_c) c_q <= mem_dout;
    end
  end

  assign mem_en   = (state == REQ_A) || (state == REQ_B) || (state == REQ_C);
  assign mem_addr = addr_q;
  assign a_out    = a_q;
  assign b_out    = b_q;
  assign c_out    = c_q;
  assign op_valid = (state == PRESENT);
  assign busy     = (state != IDLE);
  assign done     = (state == DONE);

endmodule
